// File: rtl/sip_phaser_out.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : sip_phaser_out
// Brief   : DDR byte-lane output phaser core: divided clock, tap registers,
//           OSERDES reset and burst tristate/read-enable controls.
// Revision: 1.0
//------------------------------------------------------------------------------
module sip_phaser_out #(
    parameter int CLKOUT_DIV      = 4,
    parameter int CLKOUT_DIV_POS  = 2,
    parameter int COARSE_DELAY    = 0,
    parameter int FINE_DELAY      = 0,
    parameter int OCLK_DELAY      = 0,
    parameter bit DATA_CTL_N      = 1'b0,
    parameter bit DATA_RD_CYCLES  = 1'b0,
    parameter bit SYNC_IN_DIV_RST = 1'b0,
    parameter bit EN_OSERDES_RST  = 1'b0
) (
    input  logic       i_freqrefclk,
    input  logic       i_rst_n,
    input  logic       i_coarseenable,
    input  logic       i_coarseinc,
    input  logic       i_fineenable,
    input  logic       i_fineinc,
    input  logic       i_selfineoclkdelay,
    input  logic       i_counterloaden,
    input  logic [8:0] i_counterloadval,
    input  logic       i_counterreaden,
    input  logic       i_syncin,
    input  logic       i_burstpending,
    output logic       o_oclkdiv,
    output logic       o_coarseoverflow,
    output logic       o_fineoverflow,
    output logic [8:0] o_counterreadval,
    output logic       o_oserdesrst,
    output logic       o_rdenable,
    output logic [1:0] o_dqsbus,
    output logic [1:0] o_ctsbus,
    output logic [1:0] o_dtsbus
);

    localparam logic [3:0] c_div_last = 4'(CLKOUT_DIV - 1);
    localparam logic [3:0] c_div_pos  = 4'(CLKOUT_DIV_POS);

    logic [3:0] r_div_cnt;
    logic [3:0] w_div_nxt;
    logic       w_tick;
    logic       r_tick_seen;
    logic [5:0] r_coarse_tap;
    logic [5:0] r_fine_tap;
    logic [5:0] r_oclk_tap;
    logic [5:0] w_sel_tap;
    logic [5:0] w_sel_step;
    logic       w_fine_sat;
    logic       w_coarse_sat;
    logic       r_burst;
    logic       w_unused_load_bits;

    assign w_unused_load_bits = ^i_counterloadval[8:6];

    // ---------------- divider ----------------
    assign w_tick = (r_div_cnt == c_div_last);

    always_comb begin
        w_div_nxt = r_div_cnt + 4'd1;
        if (w_tick) begin
            w_div_nxt = 4'd0;
        end
        if (SYNC_IN_DIV_RST && i_syncin) begin
            w_div_nxt = 4'd0;
        end
    end

    always_ff @(posedge i_freqrefclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= 4'd0;
            o_oclkdiv <= 1'b1;
        end else begin
            r_div_cnt <= w_div_nxt;
            o_oclkdiv <= (w_div_nxt < c_div_pos);
        end
    end

    // OSERDES reset releases on the second divider tick after reset.
    always_ff @(posedge i_freqrefclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_seen  <= 1'b0;
            o_oserdesrst <= EN_OSERDES_RST;
        end else if (w_tick) begin
            r_tick_seen <= 1'b1;
            if (r_tick_seen) begin
                o_oserdesrst <= 1'b0;
            end
        end
    end

    // ---------------- coarse tap ----------------
    assign w_coarse_sat = i_coarseinc ? (r_coarse_tap == 6'd63) : (r_coarse_tap == 6'd0);

    always_ff @(posedge i_freqrefclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_coarse_tap     <= 6'(COARSE_DELAY);
            o_coarseoverflow <= 1'b0;
        end else if (i_coarseenable) begin
            if (w_coarse_sat) begin
                o_coarseoverflow <= 1'b1;
            end else begin
                o_coarseoverflow <= 1'b0;
                r_coarse_tap     <= i_coarseinc ? r_coarse_tap + 6'd1 : r_coarse_tap - 6'd1;
            end
        end
    end

    // ---------------- fine / OCLK taps ----------------
    assign w_sel_tap  = i_selfineoclkdelay ? r_oclk_tap : r_fine_tap;
    assign w_sel_step = i_fineinc ? w_sel_tap + 6'd1 : w_sel_tap - 6'd1;
    assign w_fine_sat = i_fineinc ? (w_sel_tap == 6'd63) : (w_sel_tap == 6'd0);

    always_ff @(posedge i_freqrefclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fine_tap     <= 6'(FINE_DELAY);
            r_oclk_tap     <= 6'(OCLK_DELAY);
            o_fineoverflow <= 1'b0;
        end else if (i_counterloaden) begin
            if (i_selfineoclkdelay) begin
                r_oclk_tap <= i_counterloadval[5:0];
            end else begin
                r_fine_tap <= i_counterloadval[5:0];
            end
            o_fineoverflow <= 1'b0;
        end else if (i_fineenable) begin
            if (w_fine_sat) begin
                o_fineoverflow <= 1'b1;
            end else begin
                o_fineoverflow <= 1'b0;
                if (i_selfineoclkdelay) begin
                    r_oclk_tap <= w_sel_step;
                end else begin
                    r_fine_tap <= w_sel_step;
                end
            end
        end
    end

    always_ff @(posedge i_freqrefclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_counterreadval <= 9'd0;
        end else if (i_counterreaden) begin
            o_counterreadval <= {3'b000, w_sel_tap};
        end
    end

    // ---------------- burst controls ----------------
    always_ff @(posedge i_freqrefclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_burst <= 1'b0;
        end else if (w_tick) begin
            r_burst <= i_burstpending;
        end
    end

    assign o_dqsbus   = r_burst ? 2'b10 : 2'b00;
    assign o_rdenable = DATA_RD_CYCLES & r_burst;
    assign o_dtsbus   = DATA_CTL_N ? 2'b00 : {2{~r_burst}};
    assign o_ctsbus   = DATA_CTL_N ? {2{~r_burst}} : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_sip_phaser_out.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_sip_phaser_out
// Brief   : Directed self-checking bench with a cycle-level behavioural model.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_sip_phaser_out;

    localparam int DIV = 4;
    localparam int POS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coarseen = 0, coarseinc = 0, fineen = 0, fineinc = 0, sel = 0;
    logic       loaden = 0, readen = 0, syncin = 0, pending = 0;
    logic [8:0] loadval = 9'd0;
    logic       oclkdiv, cov, fov, oserdesrst, rden;
    logic [8:0] readval;
    logic [1:0] dqs, cts, dts;

    int total = 0;
    int bad = 0;

    int m_cnt, m_ticks, m_coarse, m_fine, m_oclk, m_cov, m_fov, m_rb, m_burst;
    bit m_valid = 0;

    sip_phaser_out #(
        .CLKOUT_DIV(DIV), .CLKOUT_DIV_POS(POS), .COARSE_DELAY(62), .FINE_DELAY(5),
        .OCLK_DELAY(0), .DATA_CTL_N(1'b0), .DATA_RD_CYCLES(1'b1),
        .SYNC_IN_DIV_RST(1'b1), .EN_OSERDES_RST(1'b1)
    ) dut (
        .i_freqrefclk(clk), .i_rst_n(rst_n),
        .i_coarseenable(coarseen), .i_coarseinc(coarseinc),
        .i_fineenable(fineen), .i_fineinc(fineinc), .i_selfineoclkdelay(sel),
        .i_counterloaden(loaden), .i_counterloadval(loadval),
        .i_counterreaden(readen), .i_syncin(syncin), .i_burstpending(pending),
        .o_oclkdiv(oclkdiv), .o_coarseoverflow(cov), .o_fineoverflow(fov),
        .o_counterreadval(readval), .o_oserdesrst(oserdesrst), .o_rdenable(rden),
        .o_dqsbus(dqs), .o_ctsbus(cts), .o_dtsbus(dts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ticks = 0; m_coarse = 62; m_fine = 5; m_oclk = 0;
        m_cov = 0; m_fov = 0; m_rb = 0; m_burst = 0;
    endtask

    // Saturating tap step: out-of-range attempt leaves the tap and raises the flag.
    task automatic tap_step(inout int tap, inout int ov, input bit inc);
        int n;
        n = inc ? tap + 1 : tap - 1;
        if (n < 0 || n > 63) ov = 1;
        else begin tap = n; ov = 0; end
    endtask

    task automatic model_step();
        bit tick;
        tick = (m_cnt == DIV - 1);
        if (readen) m_rb = sel ? m_oclk : m_fine;
        m_cnt = syncin ? 0 : (m_cnt + 1) % DIV;
        if (tick) begin m_ticks++; m_burst = pending; end
        if (coarseen) tap_step(m_coarse, m_cov, coarseinc);
        if (loaden) begin
            if (sel) m_oclk = loadval % 64; else m_fine = loadval % 64;
            m_fov = 0;
        end else if (fineen) begin
            if (sel) tap_step(m_oclk, m_fov, fineinc); else tap_step(m_fine, m_fov, fineinc);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid && rst_n) begin
            chk("m_oclkdiv", oclkdiv, (m_cnt < POS) ? 1 : 0);
            chk("m_oserdesrst", oserdesrst, (m_ticks < 2) ? 1 : 0);
            chk("m_coarseovf", cov, m_cov);
            chk("m_fineovf", fov, m_fov);
            chk("m_readval", readval, m_rb);
            chk("m_dqsbus", dqs, m_burst ? 2 : 0);
            chk("m_dtsbus", dts, m_burst ? 0 : 3);
            chk("m_ctsbus", cts, 0);
            chk("m_rdenable", rden, m_burst);
        end
    end

    // One clock: edge, model update, then past the compare point.
    task automatic cyc();
        @(posedge clk);
        #1 model_step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_oclkdiv", oclkdiv, 1);
        chk("rst_oserdesrst", oserdesrst, 1);
        chk("rst_dtsbus", dts, 2'b11);
        chk("rst_ctsbus", cts, 2'b00);
        chk("rst_readval", readval, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        m_valid = 1;

        // divider pattern 1,1,0,0 and OSERDES reset release after the 2nd tick
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("div_pattern", oclkdiv, ((i % 4) < 2) ? 1 : 0);
            if (i == 7) chk("oserdes_hold", oserdesrst, 1);
            if (i == 8) chk("oserdes_release", oserdesrst, 0);
        end

        // coarse 62 -> 63 -> overflow -> 62
        coarseen = 1; coarseinc = 1;
        cyc(); chk("coarse_to63", cov, 0);
        cyc(); chk("coarse_ovf", cov, 1);
        coarseinc = 0;
        cyc(); chk("coarse_dec_clr", cov, 0);
        coarseen = 0;

        // load beats step; readback of the loaded value
        loaden = 1; loadval = 9'h1A5; fineen = 1; fineinc = 1; sel = 0;
        cyc(); chk("load_fov", fov, 0);
        loaden = 0; fineen = 0; readen = 1;
        cyc(); chk("load_readback", readval, 9'h025);
        readen = 0;

        // OCLK tap underflow leaves fine tap alone
        sel = 1; fineen = 1; fineinc = 0;
        cyc(); chk("oclk_underflow", fov, 1);
        fineen = 0; readen = 1;
        cyc(); chk("oclk_readback", readval, 9'h000);
        sel = 0;
        cyc(); chk("fine_unchanged", readval, 9'h025);
        readen = 0;

        // load clears overflow, then step past 63
        sel = 1; loaden = 1; loadval = 9'h03F; fineen = 1; fineinc = 1;
        cyc(); chk("load_clr_ovf", fov, 0);
        loaden = 0;
        cyc(); chk("oclk_overflow", fov, 1);
        fineen = 0; sel = 0;

        // burst window
        pending = 1;
        repeat (4) cyc();
        chk("burst_dqs", dqs, 2'b10);
        chk("burst_dts", dts, 2'b00);
        chk("burst_rden", rden, 1);
        pending = 0;
        repeat (4) cyc();
        chk("idle_dqs", dqs, 2'b00);
        chk("idle_dts", dts, 2'b11);

        // SYNCIN mid-period restarts the divider
        for (int k = 0; k < 4 && m_cnt != 1; k++) cyc();
        chk("sync_align", m_cnt, 1);
        syncin = 1;
        cyc(); syncin = 0;
        chk("sync_hi0", oclkdiv, 1);
        cyc(); chk("sync_hi1", oclkdiv, 1);
        cyc(); chk("sync_lo", oclkdiv, 0);

        // mixed traffic checked by the model
        for (int i = 0; i < 48; i++) begin
            coarseen = (i % 3 == 0); coarseinc = (i % 7 < 4);
            fineen = (i % 2 == 0); fineinc = (i % 5 < 2); sel = (i % 4 >= 2);
            loaden = (i % 11 == 5); loadval = 9'(i * 37);
            readen = (i % 3 == 1); pending = (i % 9 < 5);
            syncin = (i % 13 == 6);
            cyc();
        end
        {coarseen, fineen, loaden, readen, pending, syncin} = '0;

        // asynchronous mid-operation reset
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mrst_oclkdiv", oclkdiv, 1);
        chk("mrst_oserdes", oserdesrst, 1);
        chk("mrst_fov", fov, 0);
        chk("mrst_readval", readval, 0);
        chk("mrst_dqs", dqs, 0);
        model_reset();
        #1 rst_n = 1'b1;
        repeat (10) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
